// File: rtl/e18_out_logger.sv
`default_nettype none
// ============================================================================
//  Module      : e18_out_logger
//  Description : Change-triggered capture of the e18 output vector into a
//                FWFT FIFO, with MISR signature and overflow drop counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module e18_out_logger #(
    parameter int           W           = 12,
    parameter int           DEPTH       = 4,
    parameter int           TS_W        = 8,
    parameter logic [15:0]  MISR_POLY   = 16'hB400,
    parameter logic [15:0]  MISR_SEED   = 16'hFFFF,
    parameter bit           STOP_ON_OVF = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     smp,
    input  logic [W-1:0]             y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W+W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [7:0]               drop_cnt,
    output logic [15:0]              misr
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = TS_W + W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [AW:0]     FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0]     CNT_ONE  = 1;
    localparam logic [AW-1:0]   PTR_ONE  = 1;
    localparam logic [TS_W-1:0] TS_ONE   = 1;

    logic [1:0]       state_q,  state_d;
    logic [DW-1:0]    mem_q     [DEPTH];
    logic [DW-1:0]    mem_d     [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [TS_W-1:0]  ts_q,     ts_d;
    logic [W-1:0]     last_y_q, last_y_d;
    logic [15:0]      misr_q,   misr_d;
    logic             ovf_q,    ovf_d;
    logic [7:0]       drop_q,   drop_d;

    logic capture;
    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [15:0] misr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? MISR_POLY : 16'h0000);
    endfunction

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        capture  = (state_q == S_RUN) && smp;
        push_req = capture && (y_in != last_y_q);
        full     = (count_q == FULL_LVL);
        pop      = (count_q != '0) && out_ready;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ts_d     = ts_q;
        last_y_d = last_y_q;
        misr_d   = misr_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (clr) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ts_d     = '0;
            last_y_d = '0;
            misr_d   = MISR_SEED;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            case (state_q)
                S_IDLE:  if (en) state_d = S_RUN;
                S_RUN: begin
                    if (!en)                      state_d = S_IDLE;
                    else if (drop && STOP_ON_OVF) state_d = S_HALT;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase

            if (capture) begin
                ts_d     = ts_q + TS_ONE;
                misr_d   = misr_step(misr_q) ^ 16'(y_in);
                last_y_d = y_in;
            end

            if (push) begin
                mem_d[wr_ptr_q] = {ts_q, y_in};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end

            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
            last_y_q <= '0;
            misr_q   <= MISR_SEED;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            last_y_q <= last_y_d;
            misr_q   <= misr_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = count_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
    assign misr      = misr_q;

endmodule
`default_nettype wire
